pwm_dac_stage: RTL and testbench

Output stage of the function generator. It consumes the 8-bit sample stream produced by the waveform generator, applies a 4-bit amplitude scale, and converts each scaled sample into one fixed-length PWM period for the board's RC-filtered output pin. It also emits a one-cycle period strobe. The generator may use that strobe as its advance enable, so that exactly one sample is consumed per PWM period.

---
 rtl/fgen_pkg.sv | 19 +
 rtl/pwm_dac_stage_if.sv | 35 +++
 rtl/pwm_period_counter.sv | 30 +++
 rtl/pwm_dac_stage.sv | 92 +++++++++
 tb/tb_pwm_dac_stage.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/fgen_pkg.sv
// Function generator shared types and constants.
// Used by the PWM output stage and its helpers.
package fgen_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int AMP_W_DEF  = 4;
  localparam int PERIOD_MAX = 254;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // A period of 2^w-1 cycles ends at count 2^w-2.
  function automatic int period_max(input int w);
    return (1 << w) - 2;
  endfunction

endpackage

// File: rtl/pwm_dac_stage_if.sv
// Sample stream and PWM output bundle between
// the waveform generator and the PWM output stage.
interface pwm_dac_stage_if
  import fgen_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMP_W = AMP_W_DEF
);

  logic             en;
  logic [WIDTH-1:0] sample;
  logic [AMP_W-1:0] amp;
  logic             pwm_out;
  logic             tick;
  logic             busy;

  modport master (
    output en,
    output sample,
    output amp,
    input  pwm_out,
    input  tick,
    input  busy
  );

  modport slave (
    input  en,
    input  sample,
    input  amp,
    output pwm_out,
    output tick,
    output busy
  );

endinterface

// File: rtl/pwm_period_counter.sv
// Free-running period counter 0..MAX with wrap
// and zero flags; held at zero while disabled.
module pwm_period_counter
  import fgen_pkg::*;
#(
  parameter int W   = WIDTH_DEF,
  parameter int MAX = PERIOD_MAX
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         zero
);

  assign wrap = (cnt == W'(MAX));
  assign zero = (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_dac_stage.sv
// PWM output stage: amplitude-scales each sample
// and plays it as one fixed-length PWM period.
module pwm_dac_stage
  import fgen_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMP_W = AMP_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  pwm_dac_stage_if.slave bus
);

  localparam int PROD_W = WIDTH + AMP_W + 1;

  state_t           state_q;
  state_t           state_d;
  logic             load;
  logic             run;
  logic [WIDTH-1:0] cnt;
  logic             wrap;
  logic             zero;
  logic [WIDTH-1:0] duty;
  logic [AMP_W:0]   amp_p1;
  logic [PROD_W-1:0] prod;
  logic [WIDTH-1:0] scaled;

  // amp+1 in 1..2^AMP_W, so full scale is unity gain.
  assign amp_p1 = {1'b0, bus.amp} + 1'b1;
  assign prod   = PROD_W'(bus.sample)
                * PROD_W'(amp_p1);
  assign scaled = WIDTH'(prod >> AMP_W);

  assign run = (state_q == RUN);

  pwm_period_counter #(
    .W   (WIDTH),
    .MAX (period_max(WIDTH))
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .cnt  (cnt),
    .wrap (wrap),
    .zero (zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A stop request only takes effect at the wrap.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (wrap) begin
          if (bus.en) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty <= '0;
    end else if (load) begin
      duty <= scaled;
    end
  end

  assign bus.pwm_out = run && (cnt < duty);
  assign bus.tick    = run && zero;
  assign bus.busy    = run;

endmodule

// File: tb/tb_pwm_dac_stage.sv
// Directed plus randomized bench for pwm_dac_stage
// against a per-period duty reference model.
module tb_pwm_dac_stage;
  import fgen_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pwm_dac_stage_if #(.WIDTH(8), .AMP_W(4)) bus();

  pwm_dac_stage #(.WIDTH(8), .AMP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  int cur_duty = 0;
  int gen_q[$];
  int gen_val = 0;
  int gen_dir = 1;
  bit gen_on = 0;

  function automatic int ref_scale(input int s, input int a);
    return (s * (a + 1)) / 16;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Triangle generator bouncing between 0 and 240.
  task automatic gen_step();
    if (gen_val + gen_dir * 30 > 240 ||
        gen_val + gen_dir * 30 < 0)
      gen_dir = -gen_dir;
    gen_val = gen_val + gen_dir * 30;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, 32'(bus.busy), 0);
    check({tag, ".pwm"},  32'(bus.pwm_out), 0);
    check({tag, ".tick"}, 32'(bus.tick), 0);
  endtask

  // Entered in the cnt=0 cycle of a period; leaves
  // in the first cycle after that period.
  task automatic run_period(input string tag,
                            input int c1_at,
                            input logic c1_en,
                            input int c1_amp,
                            input int c2_at,
                            input logic c2_en,
                            input bit rnd);
    int exp;
    int highs;
    int shape;
    int ticks;
    int idle;
    int rpos;
    int gen_exp;
    logic tick0;
    exp = cur_duty;
    highs = 0;
    shape = 0;
    ticks = 0;
    idle = 0;
    gen_exp = -1;
    rpos = int'($urandom_range(1, 253));
    if (gen_on && gen_q.size() > 0)
      gen_exp = gen_q.pop_front();
    tick0 = bus.tick;
    for (int i = 0; i < 255; i++) begin
      highs += (bus.pwm_out === 1'b1) ? 1 : 0;
      shape += ((bus.pwm_out === 1'b1) != (i < exp))
               ? 1 : 0;
      ticks += (bus.tick === 1'b1) ? 1 : 0;
      idle += (bus.busy !== 1'b1) ? 1 : 0;
      if (i == 0 && gen_on) begin
        gen_step();
        bus.sample = 8'(gen_val);
        gen_q.push_back(gen_val);
      end
      if (i == c1_at) begin
        bus.en = c1_en;
        if (c1_amp >= 0) bus.amp = 4'(c1_amp);
      end
      if (i == c2_at) bus.en = c2_en;
      if (rnd && i == rpos) begin
        bus.sample = 8'($urandom_range(0, 255));
        bus.amp = 4'($urandom_range(0, 15));
      end
      step();
    end
    check({tag, ".tick0"}, 32'(tick0), 1);
    check({tag, ".highs"}, highs, exp);
    check({tag, ".shape"}, shape, 0);
    check({tag, ".ticks"}, ticks, 1);
    check({tag, ".busy"}, idle, 0);
    if (gen_exp >= 0)
      check({tag, ".gen"}, highs, gen_exp);
    if (bus.en)
      cur_duty = ref_scale(int'(bus.sample),
                           int'(bus.amp));
    else
      check_idle({tag, ".stop"});
  endtask

  task automatic plain(input string tag);
    run_period(tag, -1, 1'b1, -1, -1, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    bus.en = 1'b0;
    bus.sample = '0;
    bus.amp = '0;
    step();
    step();
    check_idle("reset");
    rst = 1'b1;
    step();
    step();
    check_idle("idle");

    bus.sample = 8'd128;
    bus.amp = 4'd15;
    bus.en = 1'b1;
    cur_duty = ref_scale(128, 15);
    step();
    check("start.busy", 32'(bus.busy), 1);
    plain("p128a");
    plain("p128b");

    bus.sample = 8'd255;
    plain("p128c");
    plain("full_a");
    plain("full_b");
    bus.sample = 8'd0;
    plain("full_c");
    plain("zero_a");

    bus.sample = 8'd200;
    bus.amp = 4'd7;
    plain("zero_b");
    check("amp7.model", cur_duty, 100);
    run_period("d100", 50, 1'b1, 15, -1, 1'b1, 1'b0);
    plain("d200");

    run_period("stop10", 10, 1'b0, -1, -1, 1'b1,
               1'b0);
    step();
    check_idle("stopped");
    bus.en = 1'b1;
    cur_duty = ref_scale(int'(bus.sample),
                         int'(bus.amp));
    step();
    plain("restart");
    bus.sample = 8'd90;
    run_period("cancel", 10, 1'b0, -1, 100, 1'b1,
               1'b0);
    plain("after_cancel");

    for (int i = 0; i < 60; i++) step();
    check("rst.pre_pwm", 32'(bus.pwm_out), 1);
    rst = 1'b0;
    #1;
    check_idle("rst.async");
    step();
    check_idle("rst.hold");
    rst = 1'b1;
    cur_duty = ref_scale(int'(bus.sample),
                         int'(bus.amp));
    step();
    plain("fresh");

    gen_on = 1'b1;
    for (int k = 0; k < 20; k++) plain("gen");
    gen_on = 1'b0;

    for (int k = 0; k < 8; k++) begin
      bus.sample = 8'($urandom_range(0, 255));
      bus.amp = 4'($urandom_range(0, 15));
      run_period("rand", -1, 1'b1, -1, -1, 1'b1,
                 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
